im2_intctl: RTL and testbench
=============================

# im2_intctl

Z80 interrupt-mode-2 responder: the CPU-side counterpart of the frame INT generator. It latches interrupt requests from several on-board sources, drives a prioritised `n_int` to the CPU, answers the interrupt-acknowledge cycle with a per-source vector on the data bus, and tracks nesting by decoding RETI from the opcode stream. It sits between the peripheral request lines and the CPU data-bus mux, clocked from the 28 MHz system clock and stepped by the CPU clock strobe.

## Interface
- `SOURCES`, 3: number of request inputs (1..8); index 0 is highest priority.
- `VECTOR_BASE`, 8'hF0: vector for source 0; source i answers `VECTOR_BASE | (i<<1)`, 8-bit, bit 0 always 0.
- `clk28` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `clkcpu_ck` in 1: one-`clk28` strobe at each CPU clock rising edge.
- `m1`, `mreq`, `iorq`, `rd` in 1 each: CPU bus strobes, active-high, already decoded.
- `d_in` in 8: CPU data bus as seen by the CPLD.
- `req` in SOURCES: request pulses or levels; a rising edge sets pending.
- `mask` in SOURCES: 1 = source enabled.
- `n_int` out 1: active-low INT to CPU.
- `d_out` out 8: vector byte.
- `d_oe` out 1: data-bus mux select for `d_out`.
- `ack` out SOURCES: one-`clk28` pulse at acknowledge of that source.

## Operation
- Pending: `pend[i]` set on rising edge of `req[i]` (previous-sample compare on `clk28`), cleared on acknowledge of i. A simultaneous set and ack leaves it set.
- Candidate: lowest i with `pend[i] & mask[i]` and no in-service bit at index <= i.
- `n_int` is 0 while a candidate exists; it updates only on `clkcpu_ck`.
- INTA = `m1 & iorq`. On the first `clk28` with INTA and `clkcpu_ck`, freeze the candidate as `sel`, clear `pend[sel]`, set `isr[sel]`, and pulse `ack[sel]`. If there is no candidate (spurious INTA), `sel` is SOURCES-1 and no state changes.
- `d_out` is the vector of `sel`. `d_oe` = 1 from the cycle after the freeze until INTA deasserts.
- RETI decoder: an opcode fetch is `m1 & mreq & rd`. `d_in` is latched each `clk28` while a fetch is active; the byte is evaluated when the fetch ends.
- Decoder states:
  - IDLE: ED goes to SAW_ED; any other byte stays in IDLE.
  - SAW_ED: 4D means RETI, which clears the lowest set `isr` bit, then go to IDLE. ED stays in SAW_ED. Any other byte goes to IDLE.
- An INTA M1 cycle is not an opcode fetch and does not advance the decoder.
- Masking a source clears neither its pend nor its isr bit.

## Timing
- Reset values: `n_int`=1, `d_oe`=0, `d_out`=VECTOR_BASE, `ack`=0, all pend and isr bits 0, decoder IDLE.
- Request to `n_int` low: 2 `clk28` cycles (edge detect, pend) plus a wait for the next `clkcpu_ck`.
- INTA edge to `d_oe`: 1 `clk28`. `d_oe` falls on the `clk28` after INTA falls.
- RETI: the isr bit clears on the `clk28` after the 4D fetch ends. `n_int` can reassert at the next `clkcpu_ck`.
- Reset asserted mid-INTA: `d_oe` drops on the next cycle and the decoder returns to IDLE.

## Configuration
- Macro: `IM2_INTCTL_NESTING_EN`.
- Defined: isr tracking and the RETI decoder are as described above.
- Undefined: no isr register and no decoder. The candidate is the lowest pending enabled source, and `n_int` may reassert immediately after acknowledge.

## Structure
- Package `common`: the decoder state enum `reti_state_t` (IDLE, SAW_ED) and the opcode constants `OP_ED`=8'hED and `OP_RETI2`=8'h4D.
- Sub-module `reti_decoder`: fetch latch and state machine. Outputs a one-cycle `reti` pulse. It is instantiated only under the macro.

## Test plan
- Pulse `req[1]`, mask=3'b111, then run INTA → `n_int` goes 0 at the next `clkcpu_ck`; `d_out`=8'hF2 with `d_oe`=1; `ack[1]` pulses once; `n_int` returns to 1.
- Pulse `req[0]` and `req[2]` in the same cycle → the first INTA returns F0, the second returns F4 (with nesting off, or after RETI).
- Nesting on: acknowledge source 2, then pulse `req[0]` → `n_int` goes 0 and INTA returns F0. Fetch ED,4D → isr[0] clears while isr[2] stays set. A second RETI clears isr[2].
- Fetch ED,45 (RETN) and DD,4D → isr is unchanged. Fetch ED,ED,4D → counts as RETI.
- mask[1]=0 with `req[1]` pulsed → `n_int` stays 1. Setting mask[1]=1 → `n_int` goes 0.
- Assert `rst` during INTA → `d_oe`=0 the next cycle; all pend and isr bits are 0; `n_int`=1.

Source files
------------

// File: rtl/im2_intctl_pkg.sv
// Shared types for the IM2 interrupt responder: RETI decoder states, opcode bytes, bit helper.
// No logic, no latency; nothing here applies backpressure.
package common;

    typedef enum logic {
        IDLE   = 1'b0,
        SAW_ED = 1'b1
    } reti_state_t;

    localparam logic [7:0] OP_ED    = 8'hED;
    localparam logic [7:0] OP_RETI2 = 8'h4D;

    // Isolates the lowest set bit (zero in, zero out).
    function automatic logic [7:0] lowest_set(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/im2_intctl_reti_decoder.sv
// Watches opcode fetches for ED,4D and emits a one-cycle reti pulse as the 4D fetch ends.
// Latency: pulse in the first clk28 after the fetch strobes drop; no backpressure.
module reti_decoder
    import common::*;
(
    input  logic       clk28,
    input  logic       rst,
    input  logic       m1,
    input  logic       mreq,
    input  logic       rd,
    input  logic [7:0] d_in,
    output logic       reti
);

    logic        fetch;
    logic        fetch_q;
    logic        fetch_end;
    logic [7:0]  op;
    reti_state_t state;
    reti_state_t state_nxt;

    // INTA M1 cycles carry iorq rather than mreq, so they never look like a fetch.
    assign fetch     = m1 & mreq & rd;
    assign fetch_end = fetch_q & ~fetch;

    always_ff @(posedge clk28) begin
        if (rst) begin
            fetch_q <= 1'b0;
            op      <= 8'h00;
        end else begin
            fetch_q <= fetch;
            if (fetch) begin
                op <= d_in;
            end
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (fetch_end) begin
            case (state)
                IDLE:    state_nxt = (op == OP_ED) ? SAW_ED : IDLE;
                SAW_ED:  state_nxt = (op == OP_ED) ? SAW_ED : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        reti = 1'b0;
        if (fetch_end && (state == SAW_ED) && (op == OP_RETI2)) begin
            reti = 1'b1;
        end
    end

endmodule

// File: rtl/im2_intctl.sv
// Z80 IM2 responder: latches requests, drives prioritised n_int, answers INTA with a vector.
// Req->pend 2 clk28, n_int on next clkcpu_ck; IM2_INTCTL_NESTING_EN adds isr + RETI decode; no backpressure.
module im2_intctl
    import common::*;
#(
    parameter int unsigned SOURCES     = 3,
    parameter logic [7:0]  VECTOR_BASE = 8'hF0
) (
    input  logic               clk28,
    input  logic               rst,
    input  logic               clkcpu_ck,
    input  logic               m1,
    input  logic               mreq,
    input  logic               iorq,
    input  logic               rd,
    input  logic [7:0]         d_in,
    input  logic [SOURCES-1:0] req,
    input  logic [SOURCES-1:0] mask,
    output logic               n_int,
    output logic [7:0]         d_out,
    output logic               d_oe,
    output logic [SOURCES-1:0] ack
);

    localparam int unsigned SEL_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;

    logic [SOURCES-1:0] req_s;
    logic [SOURCES-1:0] req_q;
    logic [SOURCES-1:0] pend;
    logic [SOURCES-1:0] isr_v;
    logic [SOURCES-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   cand;
    logic               cand_vld;
    logic               blocked;
    logic               inta;
    logic               freeze;

    assign inta   = m1 & iorq;
    // d_oe doubles as "this INTA has already been answered".
    assign freeze = inta & clkcpu_ck & ~d_oe;
    assign d_out  = VECTOR_BASE | {{(7 - SEL_W){1'b0}}, sel, 1'b0};

    // An in-service bit at or above a source's priority hides it and everything below.
    always_comb begin
        cand_vld = 1'b0;
        cand     = SEL_W'(SOURCES - 1);
        blocked  = 1'b0;
        for (int i = 0; i < SOURCES; i++) begin
            blocked = blocked | isr_v[i];
            if (!cand_vld && !blocked && pend[i] && mask[i]) begin
                cand_vld = 1'b1;
                cand     = SEL_W'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (freeze && cand_vld) begin
            grant = SOURCES'(1) << cand;
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            req_s <= '0;
            req_q <= '0;
            pend  <= '0;
            n_int <= 1'b1;
            d_oe  <= 1'b0;
            sel   <= '0;
            ack   <= '0;
        end else begin
            req_s <= req;
            req_q <= req_s;
            pend  <= (pend & ~grant) | (req_s & ~req_q);
            ack   <= grant;
            d_oe  <= inta & (freeze | d_oe);
            if (clkcpu_ck) begin
                n_int <= ~cand_vld;
            end
            if (freeze) begin
                sel <= cand;
            end
        end
    end

`ifdef IM2_INTCTL_NESTING_EN
    logic               reti;
    logic [SOURCES-1:0] isr;
    logic [SOURCES-1:0] reti_clr;

    reti_decoder u_reti_decoder (
        .clk28 (clk28),
        .rst   (rst),
        .m1    (m1),
        .mreq  (mreq),
        .rd    (rd),
        .d_in  (d_in),
        .reti  (reti)
    );

    // RETI retires the highest-priority level in service, judged before this cycle's grant.
    assign reti_clr = reti ? SOURCES'(lowest_set(8'(isr))) : '0;

    always_ff @(posedge clk28) begin
        if (rst) begin
            isr <= '0;
        end else begin
            isr <= (isr & ~reti_clr) | grant;
        end
    end

    assign isr_v = isr;
`else
    logic unused_bus;

    assign isr_v      = '0;
    assign unused_bus = ^{mreq, rd, d_in};
`endif

endmodule

// File: tb/tb_im2_intctl.sv
// Bench for im2_intctl: directed table, hand sequences, and random traffic against a reference model.
module tb_im2_intctl;

    localparam int S = 3;
`ifdef IM2_INTCTL_NESTING_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic         clk28 = 1'b0;
    logic         rst = 1'b1;
    logic         clkcpu_ck = 1'b0;
    logic         m1 = 1'b0, mreq = 1'b0, iorq = 1'b0, rd = 1'b0;
    logic [7:0]   d_in = 8'h00;
    logic [S-1:0] req = '0;
    logic [S-1:0] mask = '1;
    logic         n_int;
    logic [7:0]   d_out;
    logic         d_oe;
    logic [S-1:0] ack;

    int vectors = 0;
    int miscompares = 0;

    im2_intctl dut (
        .clk28     (clk28),
        .rst       (rst),
        .clkcpu_ck (clkcpu_ck),
        .m1        (m1),
        .mreq      (mreq),
        .iorq      (iorq),
        .rd        (rd),
        .d_in      (d_in),
        .req       (req),
        .mask      (mask),
        .n_int     (n_int),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .ack       (ack)
    );

    always #5 clk28 = ~clk28;

    // Reference model: plain arrays and indices, stepped once per clk28 edge.
    bit         r_pend[S];
    bit         r_isr[S];
    bit [S-1:0] r_hist[2];        // req as sampled one and two edges ago
    bit         r_n_int = 1'b1;
    bit         r_answered = 1'b0;
    int         r_sel = 0;
    bit [S-1:0] r_ack = '0;
    bit         r_in_fetch = 1'b0;
    bit [7:0]   r_byte = 8'h00;
    bit         r_last_ed = 1'b0;

    task automatic model_edge();
        int first_isr, cand, retire;
        bit ends;
        if (rst) begin
            for (int i = 0; i < S; i++) begin r_pend[i] = 0; r_isr[i] = 0; end
            r_hist[0] = '0; r_hist[1] = '0;
            r_n_int = 1; r_answered = 0; r_sel = 0; r_ack = '0;
            r_in_fetch = 0; r_byte = 0; r_last_ed = 0;
            return;
        end
        first_isr = S;
        for (int i = S - 1; i >= 0; i--) if (r_isr[i]) first_isr = i;
        cand = -1;
        for (int i = first_isr - 1; i >= 0; i--) if (r_pend[i] && mask[i]) cand = i;
        retire = -1;
        ends = r_in_fetch && !(m1 && mreq && rd);
        if (NEST && ends && r_byte == 8'h4D && r_last_ed) retire = first_isr;
        if (ends) r_last_ed = (r_byte == 8'hED);
        if (m1 && mreq && rd) r_byte = d_in;
        r_in_fetch = m1 && mreq && rd;
        if (retire >= 0 && retire < S) r_isr[retire] = 0;
        r_ack = '0;
        if (clkcpu_ck) r_n_int = (cand < 0);
        if (m1 && iorq && clkcpu_ck && !r_answered) begin
            r_sel = (cand < 0) ? S - 1 : cand;
            if (cand >= 0) begin
                r_pend[cand] = 0;
                r_isr[cand] = NEST;
                r_ack[cand] = 1;
            end
            r_answered = 1;
        end
        if (!(m1 && iorq)) r_answered = 0;
        for (int i = 0; i < S; i++) if (r_hist[0][i] && !r_hist[1][i]) r_pend[i] = 1;
        r_hist[1] = r_hist[0];
        r_hist[0] = req;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit use_model);
        @(posedge clk28);
        model_edge();
        #1;
        if (use_model)
            check("model", {19'd0, n_int, d_oe, d_out, ack},
                  {19'd0, r_n_int, r_answered, 8'hF0 | 8'(r_sel << 1), r_ack});
    endtask

    task automatic tick(input logic c);
        clkcpu_ck = c;
        step(1'b1);
        clkcpu_ck = 1'b0;
    endtask

    task automatic pulse(input logic [S-1:0] bits);
        req = bits; tick(0);
        req = '0;   tick(0);
    endtask

    task automatic do_inta(input logic [7:0] exp_vec, input string nm);
        m1 = 1; iorq = 1;
        tick(0); tick(1);
        check(nm, {24'd0, d_out}, {24'd0, exp_vec});
        check({nm, "_oe"}, {31'd0, d_oe}, 32'd1);
        tick(0); tick(1);
        m1 = 0; iorq = 0;
        tick(0); tick(0);
        check({nm, "_oe_off"}, {31'd0, d_oe}, 32'd0);
    endtask

    task automatic fetch(input logic [7:0] b);
        m1 = 1; mreq = 1; rd = 1; d_in = b;
        tick(0); tick(0);
        m1 = 0; mreq = 0; rd = 0; d_in = 8'h00;
        tick(0); tick(0);
    endtask

    task automatic do_reset();
        rst = 1; m1 = 0; iorq = 0; mreq = 0; rd = 0; req = '0; mask = '1;
        tick(0);
        rst = 0;
        tick(0);
    endtask

    task automatic rtick();
        clkcpu_ck = ($urandom_range(0, 2) == 0);
        step(1'b1);
        clkcpu_ck = 1'b0;
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] opts [6];
        opts = '{8'hED, 8'h4D, 8'h45, 8'hDD, 8'hED, 8'h4D};
        if ($urandom_range(0, 6) == 0) return 8'($urandom);
        return opts[$urandom_range(0, 5)];
    endfunction

    typedef struct {
        logic         rst, ck, m1, iorq;
        logic [S-1:0] req, mask;
        logic         n_int, d_oe;
        logic [7:0]   d_out;
        logic [S-1:0] ack;
    } vec_t;

    vec_t tbl[21];

    initial begin
        //            rst ck m1 io req     mask   | n_int d_oe d_out  ack
        tbl[0]  = '{1, 0, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF0, 3'b000};
        tbl[1]  = '{0, 0, 0, 0, 3'b010, 3'b111, 1, 0, 8'hF0, 3'b000};
        tbl[2]  = '{0, 0, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF0, 3'b000};
        tbl[3]  = '{0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 8'hF0, 3'b000};
        tbl[4]  = '{0, 0, 1, 1, 3'b000, 3'b111, 0, 0, 8'hF0, 3'b000};
        tbl[5]  = '{0, 1, 1, 1, 3'b000, 3'b111, 0, 1, 8'hF2, 3'b010};
        tbl[6]  = '{0, 0, 1, 1, 3'b000, 3'b111, 0, 1, 8'hF2, 3'b000};
        tbl[7]  = '{0, 1, 1, 1, 3'b000, 3'b111, 1, 1, 8'hF2, 3'b000};
        tbl[8]  = '{0, 0, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF2, 3'b000};
        tbl[9]  = '{0, 1, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF2, 3'b000};
        tbl[10] = '{0, 1, 1, 1, 3'b000, 3'b111, 1, 1, 8'hF4, 3'b000};
        tbl[11] = '{0, 0, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF4, 3'b000};
        tbl[12] = '{1, 0, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF0, 3'b000};
        tbl[13] = '{0, 0, 0, 0, 3'b010, 3'b101, 1, 0, 8'hF0, 3'b000};
        tbl[14] = '{0, 0, 0, 0, 3'b000, 3'b101, 1, 0, 8'hF0, 3'b000};
        tbl[15] = '{0, 1, 0, 0, 3'b000, 3'b101, 1, 0, 8'hF0, 3'b000};
        tbl[16] = '{0, 0, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF0, 3'b000};
        tbl[17] = '{0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 8'hF0, 3'b000};
        tbl[18] = '{0, 1, 1, 1, 3'b000, 3'b111, 0, 1, 8'hF2, 3'b010};
        tbl[19] = '{1, 0, 1, 1, 3'b000, 3'b111, 1, 0, 8'hF0, 3'b000};
        tbl[20] = '{0, 1, 0, 0, 3'b000, 3'b111, 1, 0, 8'hF0, 3'b000};

        for (int k = 0; k < 21; k++) begin
            rst = tbl[k].rst; clkcpu_ck = tbl[k].ck;
            m1 = tbl[k].m1; iorq = tbl[k].iorq;
            req = tbl[k].req; mask = tbl[k].mask;
            step(1'b0);
            check($sformatf("table[%0d]", k), {19'd0, n_int, d_oe, d_out, ack},
                  {19'd0, tbl[k].n_int, tbl[k].d_oe, tbl[k].d_out, tbl[k].ack});
        end
        clkcpu_ck = 0; m1 = 0; iorq = 0; rst = 0;

        // Two simultaneous requests are answered highest priority first.
        do_reset();
        pulse(3'b101);
        tick(1);
        check("dual_nint", {31'd0, n_int}, 32'd0);
        do_inta(8'hF0, "dual_first");
`ifdef IM2_INTCTL_NESTING_EN
        fetch(8'hED); fetch(8'h4D);
`endif
        tick(1);
        check("dual_nint2", {31'd0, n_int}, 32'd0);
        do_inta(8'hF4, "dual_second");

`ifdef IM2_INTCTL_NESTING_EN
        // Nesting: a higher-priority source preempts; RETN and DD,4D do not retire.
        do_reset();
        pulse(3'b100); tick(1);
        check("nest_nint_src2", {31'd0, n_int}, 32'd0);
        do_inta(8'hF4, "nest_src2");
        pulse(3'b001); tick(1);
        check("nest_preempt_nint", {31'd0, n_int}, 32'd0);
        do_inta(8'hF0, "nest_src0");
        fetch(8'hED); fetch(8'h45);
        fetch(8'hDD); fetch(8'h4D);
        pulse(3'b010); tick(1);
        check("nest_src1_blocked", {31'd0, n_int}, 32'd1);
        fetch(8'hED); fetch(8'hED); fetch(8'h4D);
        tick(1);
        check("nest_ed_ed_4d", {31'd0, n_int}, 32'd0);
        do_inta(8'hF2, "nest_src1");
        fetch(8'hED); fetch(8'h4D);
        fetch(8'hED); fetch(8'h4D);
        pulse(3'b100); tick(1);
        check("nest_all_retired", {31'd0, n_int}, 32'd0);
        do_inta(8'hF4, "nest_src2_again");
`endif

        do_reset();
        for (int n = 0; n < 900; n++) begin
            case ($urandom_range(0, 9))
                0, 1: begin req = S'($urandom); rtick(); req = '0; rtick(); end
                2: begin req = S'($urandom); rtick(); end
                3, 4: begin
                    m1 = 1; iorq = 1;
                    repeat ($urandom_range(2, 6)) rtick();
                    m1 = 0; iorq = 0; rtick();
                end
                5, 6: begin
                    m1 = 1; mreq = 1; rd = 1; d_in = pick_byte();
                    rtick(); rtick();
                    m1 = 0; mreq = 0; rd = 0; d_in = 8'($urandom);
                    rtick();
                end
                7: begin mask = ($urandom_range(0, 3) == 0) ? S'($urandom) : '1; rtick(); end
                8: begin
                    if ($urandom_range(0, 7) == 0) rst = 1;
                    rtick();
                    rst = 0;
                end
                default: rtick();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
